// File: rtl/l1d_evict_wb_unit_pkg.sv
// Shared types and sizes for the L1D eviction write-back path.
// Optional clean-line skip is enabled by defining L1D_EVICT_CLEAN_SKIP_EN.
package l1d_evict_wb_unit_pkg;

  localparam int unsigned L1D_LINE_WIDTH           = 512;
  localparam int unsigned L1D_EVICT_BEAT_WIDTH     = 128;
  localparam int unsigned L1D_EVICT_BEAT_NUM       = L1D_LINE_WIDTH / L1D_EVICT_BEAT_WIDTH;
  localparam int unsigned L1D_EVICT_BEAT_CNT_WIDTH = $clog2(L1D_EVICT_BEAT_NUM);
  localparam int unsigned L1D_INDEX_WIDTH          = 6;
  localparam int unsigned L1D_WAY_ID_WIDTH         = 2;
  localparam int unsigned L1D_MSHR_ENTRY_NUM       = 8;
  localparam int unsigned L1D_MSHR_ID_WIDTH        = $clog2(L1D_MSHR_ENTRY_NUM);

  typedef struct packed {
    logic [L1D_INDEX_WIDTH-1:0]   index;
    logic [L1D_WAY_ID_WIDTH-1:0]  way;
    logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
  } pack_evict_req_pld;

  typedef struct packed {
    logic [L1D_EVICT_BEAT_WIDTH-1:0]     data;
    logic [L1D_EVICT_BEAT_CNT_WIDTH-1:0] beat_idx;
    logic                                last;
    logic [L1D_INDEX_WIDTH-1:0]          index;
    logic [L1D_WAY_ID_WIDTH-1:0]         way;
    logic [L1D_MSHR_ID_WIDTH-1:0]        mshr_id;
  } pack_evict_wb_pld;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WB_SEND,
    DONE
  } evict_wb_state_t;

endpackage

// File: rtl/l1d_evict_wb_unit_beat_ser.sv
// Line buffer to write-back beat serializer: holds the victim line and
// presents one beat at a time under valid/ready.
module l1d_evict_beat_ser #(
  parameter  int unsigned LINE_WIDTH = 512,
  parameter  int unsigned BEAT_WIDTH = 128,
  localparam int unsigned BEAT_NUM   = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned CNT_W      = $clog2(BEAT_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_load,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  send_en,
  input  logic                  beat_rdy,
  output logic                  beat_vld,
  output logic [BEAT_WIDTH-1:0] beat_data,
  output logic [CNT_W-1:0]      beat_idx,
  output logic                  beat_last,
  output logic                  beat_done
);

  logic [BEAT_NUM-1:0][BEAT_WIDTH-1:0] line_buf;
  logic [CNT_W-1:0]                    beat_cnt;
  logic                                beat_hs;

  always_comb begin
    beat_vld  = send_en;
    beat_hs   = send_en & beat_rdy;
    beat_last = (beat_cnt == CNT_W'(BEAT_NUM - 1));
    beat_done = beat_hs & beat_last;
    beat_data = line_buf[beat_cnt];
    beat_idx  = beat_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_buf <= '0;
      beat_cnt <= '0;
    end else begin
      if (line_load) line_buf <= line_in;
      if (beat_hs)   beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/l1d_evict_wb_unit.sv
// Evict consumer: reads the victim line from data RAM, streams it as write-back
// beats, then pulses done to the owning MSHR. Optional: L1D_EVICT_CLEAN_SKIP_EN.
module l1d_evict_wb_unit
  import l1d_evict_wb_unit_pkg::*;
#(
  parameter  int unsigned BEAT_WIDTH     = L1D_EVICT_BEAT_WIDTH,
  localparam int unsigned BEAT_NUM       = L1D_LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned BEAT_CNT_WIDTH = $clog2(BEAT_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          evict_req_vld,
  output logic                          evict_req_rdy,
  input  pack_evict_req_pld             evict_req_pld,
`ifdef L1D_EVICT_CLEAN_SKIP_EN
  input  logic                          evict_req_dirty,
`endif
  output logic                          dram_rd_vld,
  input  logic                          dram_rd_rdy,
  output logic [L1D_INDEX_WIDTH-1:0]    dram_rd_index,
  output logic [L1D_WAY_ID_WIDTH-1:0]   dram_rd_way,
  input  logic                          dram_rsp_vld,
  input  logic [L1D_LINE_WIDTH-1:0]     dram_rsp_data,
  output logic                          wb_vld,
  input  logic                          wb_rdy,
  output pack_evict_wb_pld              wb_pld,
  output logic [L1D_MSHR_ENTRY_NUM-1:0] v_evict_done
);

  evict_wb_state_t         state_q, state_d;
  pack_evict_req_pld       req_q;
  logic                    req_accept;
  logic                    line_load;
  logic                    send_en;
  logic [BEAT_WIDTH-1:0]   beat_data;
  logic [BEAT_CNT_WIDTH-1:0] beat_idx;
  logic                    beat_last;
  logic                    beat_done;

  always_comb begin
    state_d       = state_q;
    evict_req_rdy = 1'b0;
    req_accept    = 1'b0;
    dram_rd_vld   = 1'b0;
    line_load     = 1'b0;
    send_en       = 1'b0;
    case (state_q)
      IDLE: begin
        evict_req_rdy = 1'b1;
        if (evict_req_vld) begin
          req_accept = 1'b1;
`ifdef L1D_EVICT_CLEAN_SKIP_EN
          state_d = evict_req_dirty ? RD_REQ : DONE;
`else
          state_d = RD_REQ;
`endif
        end
      end
      RD_REQ: begin
        dram_rd_vld = 1'b1;
        if (dram_rd_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (dram_rsp_vld) begin
          line_load = 1'b1;
          state_d   = WB_SEND;
        end
      end
      WB_SEND: begin
        send_en = 1'b1;
        if (beat_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_accept) req_q <= evict_req_pld;
    end
  end

  l1d_evict_beat_ser #(
    .LINE_WIDTH (L1D_LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_beat_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_load (line_load),
    .line_in   (dram_rsp_data),
    .send_en   (send_en),
    .beat_rdy  (wb_rdy),
    .beat_vld  (wb_vld),
    .beat_data (beat_data),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .beat_done (beat_done)
  );

  always_comb begin
    dram_rd_index   = req_q.index;
    dram_rd_way     = req_q.way;
    wb_pld.data     = beat_data;
    wb_pld.beat_idx = beat_idx;
    wb_pld.last     = beat_last;
    wb_pld.index    = req_q.index;
    wb_pld.way      = req_q.way;
    wb_pld.mshr_id  = req_q.mshr_id;
    v_evict_done    = '0;
    if (state_q == DONE) v_evict_done[req_q.mshr_id] = 1'b1;
  end

  // RAM read latency is at least one cycle, so no response may coincide with the request handshake.
  a_rsp_not_with_req: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RD_REQ && dram_rd_rdy) |-> !dram_rsp_vld);

  a_mshr_id_range: assert property (@(posedge clk) disable iff (!rst_n)
    (evict_req_vld && evict_req_rdy) |-> (32'(evict_req_pld.mshr_id) < L1D_MSHR_ENTRY_NUM));

endmodule

// File: tb/tb_l1d_evict_wb_unit.sv
// Self-checking bench for l1d_evict_wb_unit: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_l1d_evict_wb_unit;
  import l1d_evict_wb_unit_pkg::*;

  localparam int BW = L1D_EVICT_BEAT_WIDTH;
  localparam int NB = L1D_LINE_WIDTH / L1D_EVICT_BEAT_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          evict_req_vld;
  logic                          evict_req_rdy;
  pack_evict_req_pld             evict_req_pld;
`ifdef L1D_EVICT_CLEAN_SKIP_EN
  logic                          evict_req_dirty;
`endif
  logic                          dram_rd_vld;
  logic                          dram_rd_rdy;
  logic [L1D_INDEX_WIDTH-1:0]    dram_rd_index;
  logic [L1D_WAY_ID_WIDTH-1:0]   dram_rd_way;
  logic                          dram_rsp_vld;
  logic [L1D_LINE_WIDTH-1:0]     dram_rsp_data;
  logic                          wb_vld;
  logic                          wb_rdy;
  pack_evict_wb_pld              wb_pld;
  logic [L1D_MSHR_ENTRY_NUM-1:0] v_evict_done;

  l1d_evict_wb_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .evict_req_vld   (evict_req_vld),
    .evict_req_rdy   (evict_req_rdy),
    .evict_req_pld   (evict_req_pld),
`ifdef L1D_EVICT_CLEAN_SKIP_EN
    .evict_req_dirty (evict_req_dirty),
`endif
    .dram_rd_vld     (dram_rd_vld),
    .dram_rd_rdy     (dram_rd_rdy),
    .dram_rd_index   (dram_rd_index),
    .dram_rd_way     (dram_rd_way),
    .dram_rsp_vld    (dram_rsp_vld),
    .dram_rsp_data   (dram_rsp_data),
    .wb_vld          (wb_vld),
    .wb_rdy          (wb_rdy),
    .wb_pld          (wb_pld),
    .v_evict_done    (v_evict_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] id);
    onehot = 8'd1 << id;
  endfunction

  // Backing store contents of the data RAM, one line per (index, way).
  logic [511:0] mem [64][4];

  // Data RAM model with programmable read latency.
  int           ram_lat = 1;
  int           rsp_cnt = 0;
  logic [511:0] rsp_line;
  initial begin
    dram_rsp_vld  = 1'b0;
    dram_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) rsp_cnt = 0;
      else if (dram_rd_vld && dram_rd_rdy) begin
        rsp_cnt  = ram_lat;
        rsp_line = mem[dram_rd_index][dram_rd_way];
      end
      @(posedge clk);
      #1;
      dram_rsp_vld = 1'b0;
      for (int k = 0; k < 16; k++) dram_rsp_data[k*32 +: 32] = $urandom;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          dram_rsp_vld  = 1'b1;
          dram_rsp_data = rsp_line;
        end
      end
    end
  end

  // Transaction-level reference: one eviction in flight = read, NB beats, done.
  bit                have_cur, rd_done, got_rsp, finished, skip;
  int                beats;
  pack_evict_req_pld cur;
  always @(negedge clk) begin
    logic         exp_rd, exp_wb;
    logic [7:0]   exp_done;
    logic [511:0] ln;
    if (!rst_n) begin
      chk("rst_req_rdy", evict_req_rdy, 1);
      chk("rst_rd_vld", dram_rd_vld, 0);
      chk("rst_wb_vld", wb_vld, 0);
      chk("rst_done", v_evict_done, 0);
      have_cur = 0;
    end else begin
      exp_rd   = have_cur && !rd_done && !skip;
      exp_wb   = have_cur && got_rsp && (beats < NB);
      exp_done = (have_cur && finished) ? onehot(cur.mshr_id) : 8'h00;
      chk("req_rdy", evict_req_rdy, !have_cur);
      chk("rd_vld", dram_rd_vld, exp_rd);
      if (exp_rd) begin
        chk("rd_index", dram_rd_index, cur.index);
        chk("rd_way", dram_rd_way, cur.way);
      end
      chk("wb_vld", wb_vld, exp_wb);
      if (exp_wb) begin
        ln = mem[cur.index][cur.way];
        chk("wb_data", wb_pld.data, ln[beats*BW +: BW]);
        chk("wb_beat_idx", wb_pld.beat_idx, beats);
        chk("wb_last", wb_pld.last, beats == NB - 1);
        chk("wb_index", wb_pld.index, cur.index);
        chk("wb_way", wb_pld.way, cur.way);
        chk("wb_mshr_id", wb_pld.mshr_id, cur.mshr_id);
      end
      chk("done", v_evict_done, exp_done);
      if (exp_done != 0) have_cur = 0;
      else if (have_cur) begin
        if (exp_rd && dram_rd_rdy) rd_done = 1;
        else if (rd_done && !got_rsp && dram_rsp_vld) got_rsp = 1;
        if (exp_wb && wb_rdy) begin
          beats++;
          if (beats == NB) finished = 1;
        end
      end else if (evict_req_vld) begin
        cur      = evict_req_pld;
        have_cur = 1;
`ifdef L1D_EVICT_CLEAN_SKIP_EN
        skip = !evict_req_dirty;
`else
        skip = 0;
`endif
        finished = skip;
        rd_done  = 0;
        got_rsp  = 0;
        beats    = 0;
      end
    end
  end

  typedef struct {
    logic [5:0] index;
    logic [1:0] way;
    logic [2:0] mshr;
    int         rs;
    int         st_beat;
    int         st_len;
    int         lat;
    logic [7:0] exp_done;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  // One request; cycles counted from the accept cycle (cycle 0) to the done pulse.
  task automatic run_txn(input vec_t v);
    int c = 0;
    int st_left = v.st_len;
    bit got = 0;
    ram_lat = v.lat;
    evict_req_pld = '{index: v.index, way: v.way, mshr_id: v.mshr};
`ifdef L1D_EVICT_CLEAN_SKIP_EN
    evict_req_dirty = 1'b1;
`endif
    evict_req_vld = 1'b1;
    dram_rd_rdy   = (v.rs == 0);
    wb_rdy        = 1'b1;
    while (c < 100 && !got) begin
      @(posedge clk);
      #1;
      c++;
      evict_req_vld = 1'b0;
      dram_rd_rdy   = (c >= 1 + v.rs);
      if (wb_vld && int'(wb_pld.beat_idx) == v.st_beat && st_left > 0) begin
        wb_rdy = 1'b0;
        st_left--;
      end else wb_rdy = 1'b1;
      if (v_evict_done != 0) begin
        got = 1;
        chk("vec_done_value", v_evict_done, v.exp_done);
        chk("vec_done_latency", c, v.exp_lat);
      end
    end
    if (!got) chk("vec_done_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("vec_done_one_cycle", v_evict_done, 0);
  endtask

  initial begin
    int d[2];
    int t[2];
    int nd;
    bit drop_next, found, any_done;
    int acc_n, done_n;
    bit prev_acc;

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 16; k++) mem[i][j][k*32 +: 32] = $urandom;

    rst_n         = 1'b1;
    evict_req_vld = 1'b0;
    evict_req_pld = '0;
`ifdef L1D_EVICT_CLEAN_SKIP_EN
    evict_req_dirty = 1'b1;
`endif
    dram_rd_rdy   = 1'b1;
    wb_rdy        = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_rdy", evict_req_rdy, 1);
    chk("reset_rd_vld", dram_rd_vld, 0);
    chk("reset_wb_vld", wb_vld, 0);
    chk("reset_done", v_evict_done, 0);
    chk("reset_wb_pld_clear", wb_pld, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //          index  way   mshr  rs st_beat st_len lat exp_done exp_lat
    vecs[0] = '{6'h12, 2'd3, 3'd5, 0, 0,      0,     1,  8'h20,   7};
    vecs[1] = '{6'h05, 2'd1, 3'd0, 0, 1,      5,     1,  8'h01,   12};
    vecs[2] = '{6'h3F, 2'd2, 3'd3, 3, 0,      0,     1,  8'h08,   10};
    vecs[3] = '{6'h00, 2'd0, 3'd6, 0, 0,      0,     3,  8'h40,   9};
    vecs[4] = '{6'h2A, 2'd1, 3'd4, 2, 3,      2,     2,  8'h10,   12};
    vecs[5] = '{6'h11, 2'd2, 3'd7, 1, 0,      1,     1,  8'h80,   9};
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Back-to-back: second request held valid while the first is in flight.
    ram_lat       = 1;
    dram_rd_rdy   = 1'b1;
    wb_rdy        = 1'b1;
    nd            = 0;
    drop_next     = 0;
    evict_req_pld = '{index: 6'h21, way: 2'd2, mshr_id: 3'd2};
    evict_req_vld = 1'b1;
    @(posedge clk);
    #1;
    evict_req_pld = '{index: 6'h0C, way: 2'd1, mshr_id: 3'd7};
    for (int c = 1; c < 60 && nd < 2; c++) begin
      @(posedge clk);
      #1;
      if (drop_next) evict_req_vld = 1'b0;
      drop_next = evict_req_vld && evict_req_rdy;
      if (v_evict_done != 0) begin
        d[nd] = int'(v_evict_done);
        t[nd] = c;
        nd++;
      end
    end
    evict_req_vld = 1'b0;
    chk("b2b_done_count", nd, 2);
    if (nd == 2) begin
      chk("b2b_first_done", d[0], 8'h04);
      chk("b2b_second_done", d[1], 8'h80);
      chk("b2b_done_gap", t[1] - t[0], 8);
    end
    @(posedge clk);
    #1;

    // Reset while beat 2 is on the write-back channel.
    evict_req_pld = '{index: 6'h08, way: 2'd1, mshr_id: 3'd3};
    evict_req_vld = 1'b1;
    @(posedge clk);
    #1;
    evict_req_vld = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (wb_vld && wb_pld.beat_idx == 2'd2) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rst_mid_reached_beat2", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_rdy", evict_req_rdy, 1);
    chk("rst_mid_rd_vld", dram_rd_vld, 0);
    chk("rst_mid_wb_vld", wb_vld, 0);
    chk("rst_mid_done", v_evict_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    any_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (v_evict_done != 0) any_done = 1;
    end
    chk("rst_mid_no_done", any_done, 0);
    run_txn(vecs[0]);

`ifdef L1D_EVICT_CLEAN_SKIP_EN
    // Clean victim: done the cycle after accept, no RAM read, no beats.
    evict_req_dirty = 1'b0;
    evict_req_pld   = '{index: 6'h30, way: 2'd0, mshr_id: 3'd1};
    evict_req_vld   = 1'b1;
    @(posedge clk);
    #1;
    evict_req_vld   = 1'b0;
    evict_req_dirty = 1'b1;
    chk("skip_done", v_evict_done, 8'h02);
    chk("skip_no_rd", dram_rd_vld, 0);
    chk("skip_no_wb", wb_vld, 0);
    @(posedge clk);
    #1;
    chk("skip_done_cleared", v_evict_done, 0);
    chk("skip_req_rdy", evict_req_rdy, 1);
`endif

    // Randomized traffic with random back-pressure and RAM latency.
    acc_n    = 0;
    done_n   = 0;
    prev_acc = 0;
    for (int cyc = 0; cyc < 6000 && !(acc_n >= 40 && done_n == acc_n && !evict_req_vld); cyc++) begin
      @(posedge clk);
      #1;
      if (v_evict_done != 0) done_n++;
      if (prev_acc) begin
        evict_req_vld = 1'b0;
        acc_n++;
      end
      dram_rd_rdy = ($urandom_range(0, 3) != 0);
      wb_rdy      = ($urandom_range(0, 3) != 0);
      ram_lat     = $urandom_range(1, 3);
      if (!evict_req_vld && acc_n < 40 && $urandom_range(0, 2) == 0) begin
        evict_req_pld = '{index: 6'($urandom), way: 2'($urandom), mshr_id: 3'($urandom)};
`ifdef L1D_EVICT_CLEAN_SKIP_EN
        evict_req_dirty = 1'($urandom);
`endif
        evict_req_vld = 1'b1;
      end
      prev_acc = evict_req_vld && evict_req_rdy;
    end
    chk("rand_accepted", acc_n, 40);
    chk("rand_done_count", done_n, acc_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
